// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - EX-stage branch resolver with 2-bit BHT predictor and registered redirect
// Optional BRANCH_STATS_EN adds br_count / miss_count event counters.
module branch_predict_unit #(
    parameter int         XLEN     = 32,
    parameter int         BHT_IDX  = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_predict,
    input  logic            e_valid,
    input  logic [2:0]      e_signal,
    input  logic [XLEN-1:0] e_pc,
    input  logic [XLEN-1:0] e_data1,
    input  logic [XLEN-1:0] e_data2,
    input  logic            e_pred,
    input  logic [XLEN-1:0] e_target,
    input  logic            e_stall,
    output logic            taken,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     miss_count
`endif
);

    localparam int ENTRIES = 1 << BHT_IDX;

    logic [1:0]         bht [ENTRIES];
    logic [BHT_IDX-1:0] f_idx;
    logic [BHT_IDX-1:0] e_idx;
    logic               eq;
    logic               lt;
    logic               ltu;
    logic               res_taken;
    logic               is_cond;
    logic               accept;
    logic               mispredict;
    logic [1:0]         cur_cnt;
    logic [1:0]         next_cnt;
    logic               unused_f_pc_bits;

    assign f_idx            = f_pc[BHT_IDX+1:2];
    assign e_idx            = e_pc[BHT_IDX+1:2];
    assign unused_f_pc_bits = ^{f_pc[XLEN-1:BHT_IDX+2], f_pc[1:0]};

    // Read is from the registered table, so a same-index update this cycle is not visible yet.
    assign f_predict = bht[f_idx][1];

    assign eq  = (e_data1 == e_data2);
    assign lt  = ($signed(e_data1) < $signed(e_data2));
    assign ltu = (e_data1 < e_data2);

    always_comb begin
        res_taken = 1'b0;
        is_cond   = 1'b0;
        case (e_signal)
            3'd1: begin res_taken = eq;   is_cond = 1'b1; end
            3'd2: begin res_taken = !eq;  is_cond = 1'b1; end
            3'd3: begin res_taken = lt;   is_cond = 1'b1; end
            3'd4: begin res_taken = !lt;  is_cond = 1'b1; end
            3'd5: begin res_taken = ltu;  is_cond = 1'b1; end
            3'd6: begin res_taken = !ltu; is_cond = 1'b1; end
            3'd7: res_taken = 1'b1;
            default: res_taken = 1'b0;
        endcase
    end

    // An instruction seen while flush is high is on the wrong path and is dropped.
    assign accept     = e_valid && !e_stall && (e_signal != 3'd0) && !flush;
    assign mispredict = (e_pred != res_taken);

    assign cur_cnt = bht[e_idx];
    always_comb begin
        next_cnt = cur_cnt;
        if (res_taken) begin
            if (cur_cnt != 2'd3) next_cnt = cur_cnt + 2'd1;
        end else begin
            if (cur_cnt != 2'd0) next_cnt = cur_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= CNT_INIT;
            end
            taken       <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            taken <= accept && res_taken;
            flush <= accept && mispredict;
            if (accept && mispredict) begin
                redirect_pc <= res_taken ? e_target : (e_pc + XLEN'(4));
            end else begin
                redirect_pc <= '0;
            end
            if (accept && is_cond) begin
                bht[e_idx] <= next_cnt;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (accept && is_cond)    br_count   <= br_count + 32'd1;
            if (accept && mispredict) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] f_pc;
    logic        f_predict;
    logic        e_valid;
    logic [2:0]  e_signal;
    logic [31:0] e_pc;
    logic [31:0] e_data1;
    logic [31:0] e_data2;
    logic        e_pred;
    logic [31:0] e_target;
    logic        e_stall;
    logic        taken;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    branch_predict_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .f_pc        (f_pc),
        .f_predict   (f_predict),
        .e_valid     (e_valid),
        .e_signal    (e_signal),
        .e_pc        (e_pc),
        .e_data1     (e_data1),
        .e_data2     (e_data2),
        .e_pred      (e_pred),
        .e_target    (e_target),
        .e_stall     (e_stall),
        .taken       (taken),
        .flush       (flush),
        .redirect_pc (redirect_pc)
`ifdef BRANCH_STATS_EN
        ,
        .br_count    (br_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sig, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic pred, input logic [31:0] tgt);
        e_valid  = 1'b1;
        e_stall  = 1'b0;
        e_signal = sig;
        e_pc     = pc;
        e_data1  = d1;
        e_data2  = d2;
        e_pred   = pred;
        e_target = tgt;
    endtask

    task automatic idle();
        e_valid  = 1'b0;
        e_signal = 3'd0;
        e_stall  = 1'b0;
    endtask

    task automatic outs(input string tag, input logic t, input logic f, input logic [31:0] r);
        chk({tag, "_taken"}, {31'd0, taken}, {31'd0, t});
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, f});
        chk({tag, "_redir"}, redirect_pc, r);
    endtask

    task automatic pred_chk(input string tag, input logic [31:0] pc, input logic exp);
        f_pc = pc;
        #1;
        chk(tag, {31'd0, f_predict}, {31'd0, exp});
    endtask

    initial begin
        reset_n = 1'b0;
        f_pc    = 32'h100;
        idle();
        e_pc = '0; e_data1 = '0; e_data2 = '0; e_pred = 1'b0; e_target = '0;
        #12;
        outs("reset", 1'b0, 1'b0, 32'h0);
        pred_chk("reset_pred_100", 32'h100, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // BEQ taken, predicted not-taken
        drive(3'd1, 32'h100, 32'd5, 32'd5, 1'b0, 32'h180);
        tick();
        outs("beq", 1'b1, 1'b1, 32'h180);
        idle();
        pred_chk("beq_pred_after", 32'h100, 1'b1);
        tick();
        outs("beq_clear", 1'b0, 1'b0, 32'h0);

        // BLT signed: -1 < 1 taken, predicted taken
        drive(3'd3, 32'h140, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h300);
        tick();
        outs("blt", 1'b1, 1'b0, 32'h0);
        // BLTU: 0xFFFFFFFF < 1 false, predicted taken
        drive(3'd5, 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h400);
        tick();
        outs("bltu", 1'b0, 1'b1, 32'h204);
        idle();
        pred_chk("bltu_pred_alias_100", 32'h100, 1'b0);
        pred_chk("blt_pred_140", 32'h140, 1'b1);
        tick();

        // Saturation at 0xC0: four taken from 1 -> 3
        for (int i = 0; i < 4; i++) begin
            drive(3'd2, 32'h0C0, 32'd1, 32'd2, 1'b1, 32'h700);
            tick();
            chk("bne_t_flush", {31'd0, flush}, 32'd0);
        end
        idle();
        pred_chk("sat_hi_pred", 32'h0C0, 1'b1);
        drive(3'd2, 32'h0C0, 32'd3, 32'd3, 1'b0, 32'h700);
        tick();
        idle();
        pred_chk("sat_hi_after1nt", 32'h0C0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(3'd2, 32'h0C0, 32'd3, 32'd3, 1'b0, 32'h700);
            tick();
            chk("bne_nt_taken", {31'd0, taken}, 32'd0);
        end
        idle();
        pred_chk("sat_lo_pred", 32'h0C0, 1'b0);
        drive(3'd2, 32'h0C0, 32'd1, 32'd2, 1'b1, 32'h700);
        tick();
        chk("lo_taken1_flush", {31'd0, flush}, 32'd0);
        idle();
        pred_chk("sat_lo_then1", 32'h0C0, 1'b0);
        drive(3'd2, 32'h0C0, 32'd1, 32'd2, 1'b1, 32'h700);
        pred_chk("same_idx_preupdate", 32'h0C0, 1'b0);
        tick();
        idle();
        pred_chk("sat_lo_then2", 32'h0C0, 1'b1);

        // Mispredict then wrong-path instruction during flush
        drive(3'd1, 32'h0C0, 32'd1, 32'd2, 1'b1, 32'h800);
        tick();
        outs("mis_n1", 1'b0, 1'b1, 32'h0C4);
        drive(3'd1, 32'h0C0, 32'd7, 32'd7, 1'b0, 32'h900);
        tick();
        outs("wrongpath", 1'b0, 1'b0, 32'h0);
        idle();
        pred_chk("wrongpath_bht", 32'h0C0, 1'b0);
        tick();

        // Jump: always taken, no BHT update
        drive(3'd7, 32'h100, 32'd0, 32'd0, 1'b0, 32'h500);
        tick();
        outs("jal", 1'b1, 1'b1, 32'h500);
        idle();
        pred_chk("jal_bht", 32'h100, 1'b0);
        tick();
        drive(3'd0, 32'h100, 32'd1, 32'd1, 1'b1, 32'h600);
        tick();
        outs("code0", 1'b0, 1'b0, 32'h0);
        idle();
        tick();

        // Stall holds a taken BGE for three cycles
        drive(3'd4, 32'h100, 32'd5, 32'd5, 1'b0, 32'h600);
        e_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs("stall", 1'b0, 1'b0, 32'h0);
        end
        pred_chk("stall_bht", 32'h100, 1'b0);
        e_stall = 1'b0;
        tick();
        outs("unstall", 1'b1, 1'b1, 32'h600);
        idle();
        pred_chk("unstall_bht", 32'h100, 1'b1);
`ifdef BRANCH_STATS_EN
        chk("br_count", br_count, 32'd16);
        chk("miss_count", miss_count, 32'd5);
`endif

        // Asynchronous reset in the middle of the flush pulse
        reset_n = 1'b0;
        #1;
        outs("async_rst", 1'b0, 1'b0, 32'h0);
        pred_chk("rst_bht_100", 32'h100, 1'b0);
        pred_chk("rst_bht_140", 32'h140, 1'b0);
`ifdef BRANCH_STATS_EN
        chk("br_count_rst", br_count, 32'd0);
        chk("miss_count_rst", miss_count, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        outs("post_rst", 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
